// File: rtl/de_stage_pkg.sv
// rtl/de_stage_pkg.sv - shared widths, op codes, opcodes and latch layouts for the decode stage
package de_stage_pkg;

    localparam int DBITS     = 32;
    localparam int INSTBITS  = 32;
    localparam int REGNOBITS = 5;
    localparam int REGWORDS  = 32;
    localparam int IOPBITS   = 6;

    localparam int                          BUS_CANARY_WIDTH = 4;
    localparam logic [BUS_CANARY_WIDTH-1:0] BUS_CANARY_VALUE = 4'hA;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [IOPBITS-1:0] {
        INVALID_I = 6'd0,
        ADD_I,  SUB_I,  AND_I,  OR_I,   XOR_I,  SLT_I,  SLTU_I,
        SRA_I,  SRL_I,  SLL_I,
        ADDI_I, ANDI_I, ORI_I,  XORI_I, SLTI_I, SLTIU_I,
        SRAI_I, SRLI_I, SLLI_I,
        LUI_I,  AUIPC_I,
        LW_I,   SW_I,
        JAL_I,  JALR_I,
        BEQ_I,  BNE_I,  BLT_I,  BGE_I,  BLTU_I, BGEU_I
    } op_e;

    typedef struct packed {
        logic                        valid;
        logic [INSTBITS-1:0]         inst;
        logic [DBITS-1:0]            PC;
        logic [DBITS-1:0]            pcplus;
        logic [DBITS-1:0]            inst_count;
        logic [BUS_CANARY_WIDTH-1:0] bus_canary;
    } fe_latch_t;

    typedef struct packed {
        logic                 wr_reg_WB;
        logic [REGNOBITS-1:0] wregno_WB;
        logic [DBITS-1:0]     regval_WB;
    } wb_to_de_t;

    typedef struct packed {
        logic                        valid;
        logic [INSTBITS-1:0]         inst;
        logic [DBITS-1:0]            PC;
        logic [DBITS-1:0]            pcplus;
        op_e                         op_I;
        logic [DBITS-1:0]            inst_count;
        logic [DBITS-1:0]            rs1_val;
        logic [DBITS-1:0]            rs2_val;
        logic [REGNOBITS-1:0]        wregno;
        logic                        wr_reg;
        logic [DBITS-1:0]            sxt_imm;
        logic [BUS_CANARY_WIDTH-1:0] bus_canary;
    } de_latch_t;

    localparam int FE_latch_WIDTH      = $bits(fe_latch_t);
    localparam int DE_latch_WIDTH      = $bits(de_latch_t);
    localparam int from_WB_to_DE_WIDTH = $bits(wb_to_de_t);
    localparam int from_DE_to_FE_WIDTH = 1;

endpackage

// File: rtl/de_stage_if.sv
// rtl/de_stage_if.sv - latch and side-band bundle between FE, AGEX, WB and the decode stage
interface de_stage_if;

    de_stage_pkg::fe_latch_t from_FE_latch;
    logic                    from_AGEX_to_DE;
    de_stage_pkg::wb_to_de_t from_WB_to_DE;
    de_stage_pkg::de_latch_t DE_latch_out;
    logic                    from_DE_to_FE;

    // Surrounding pipeline side
    modport master (
        output from_FE_latch,
        output from_AGEX_to_DE,
        output from_WB_to_DE,
        input  DE_latch_out,
        input  from_DE_to_FE
    );

    // Decode stage side
    modport slave (
        input  from_FE_latch,
        input  from_AGEX_to_DE,
        input  from_WB_to_DE,
        output DE_latch_out,
        output from_DE_to_FE
    );

endinterface

// File: rtl/de_regfile.sv
// rtl/de_regfile.sv - 32x32 register file, one write port, two write-through read ports
module de_regfile
    import de_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [REGNOBITS-1:0] waddr_i,
    input  logic [DBITS-1:0]     wdata_i,
    input  logic [REGNOBITS-1:0] raddr1_i,
    output logic [DBITS-1:0]     rdata1_o,
    input  logic [REGNOBITS-1:0] raddr2_i,
    output logic [DBITS-1:0]     rdata2_o
);

    logic [DBITS-1:0] regs_q [REGWORDS];

    // Architectural state: cleared on reset, x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGWORDS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // x0 reads zero; a same-cycle WB write is forwarded so the reader never sees stale data
    assign rdata1_o = (raddr1_i == '0)                     ? '0      :
                      (we_i && (waddr_i == raddr1_i))      ? wdata_i :
                                                             regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                     ? '0      :
                      (we_i && (waddr_i == raddr2_i))      ? wdata_i :
                                                             regs_q[raddr2_i];

endmodule

// File: rtl/de_stage.sv
// rtl/de_stage.sv - RV32I decode / operand fetch with busy-bit hazard tracking
module de_stage
    import de_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    de_stage_if.slave bus
);

    fe_latch_t fe;
    wb_to_de_t wb;
    logic      br_cond_AGEX;

    assign fe           = bus.from_FE_latch;
    assign wb           = bus.from_WB_to_DE;
    assign br_cond_AGEX = bus.from_AGEX_to_DE;

    // The FE canary is only of interest to the bench; fold it away deliberately
    logic unused_fe_canary;
    assign unused_fe_canary = ^fe.bus_canary;

    // Instruction fields
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [REGNOBITS-1:0] rd;
    logic [REGNOBITS-1:0] rs1;
    logic [REGNOBITS-1:0] rs2;

    assign opcode = fe.inst[6:0];
    assign rd     = fe.inst[11:7];
    assign funct3 = fe.inst[14:12];
    assign rs1    = fe.inst[19:15];
    assign rs2    = fe.inst[24:20];
    assign funct7 = fe.inst[31:25];

    // Sign-extended immediates for each format
    logic [DBITS-1:0] imm_i;
    logic [DBITS-1:0] imm_s;
    logic [DBITS-1:0] imm_b;
    logic [DBITS-1:0] imm_u;
    logic [DBITS-1:0] imm_j;

    assign imm_i = {{20{fe.inst[31]}}, fe.inst[31:20]};
    assign imm_s = {{20{fe.inst[31]}}, fe.inst[31:25], fe.inst[11:7]};
    assign imm_b = {{19{fe.inst[31]}}, fe.inst[31], fe.inst[7], fe.inst[30:25], fe.inst[11:8], 1'b0};
    assign imm_u = {fe.inst[31:12], 12'b0};
    assign imm_j = {{11{fe.inst[31]}}, fe.inst[31], fe.inst[19:12], fe.inst[20], fe.inst[30:21], 1'b0};

    op_e              dec_op;
    logic [DBITS-1:0] dec_imm;
    logic             fmt_wr;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             dec_wr_reg;

    // Decode: format picks immediate and operand usage; any unrecognised encoding is neutralised
    always_comb begin
        dec_op   = INVALID_I;
        dec_imm  = '0;
        fmt_wr   = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                fmt_wr   = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_op = ADD_I;
                        3'b001:  dec_op = SLL_I;
                        3'b010:  dec_op = SLT_I;
                        3'b011:  dec_op = SLTU_I;
                        3'b100:  dec_op = XOR_I;
                        3'b101:  dec_op = SRL_I;
                        3'b110:  dec_op = OR_I;
                        default: dec_op = AND_I;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) dec_op = SUB_I;
                    else if (funct3 == 3'b101) dec_op = SRA_I;
                end
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1;
                fmt_wr   = 1'b1;
                dec_imm  = imm_i;
                case (funct3)
                    3'b000: dec_op = ADDI_I;
                    3'b010: dec_op = SLTI_I;
                    3'b011: dec_op = SLTIU_I;
                    3'b100: dec_op = XORI_I;
                    3'b110: dec_op = ORI_I;
                    3'b111: dec_op = ANDI_I;
                    3'b001: if (funct7 == 7'b0000000) dec_op = SLLI_I;
                    default: begin
                        if (funct7 == 7'b0000000) dec_op = SRLI_I;
                        else if (funct7 == 7'b0100000) dec_op = SRAI_I;
                    end
                endcase
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                fmt_wr   = 1'b1;
                dec_imm  = imm_i;
                if (funct3 == 3'b010) dec_op = LW_I;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                dec_imm  = imm_s;
                if (funct3 == 3'b010) dec_op = SW_I;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                dec_imm  = imm_b;
                case (funct3)
                    3'b000:  dec_op = BEQ_I;
                    3'b001:  dec_op = BNE_I;
                    3'b100:  dec_op = BLT_I;
                    3'b101:  dec_op = BGE_I;
                    3'b110:  dec_op = BLTU_I;
                    3'b111:  dec_op = BGEU_I;
                    default: dec_op = INVALID_I;
                endcase
            end
            OPC_LUI: begin
                fmt_wr  = 1'b1;
                dec_imm = imm_u;
                dec_op  = LUI_I;
            end
            OPC_AUIPC: begin
                fmt_wr  = 1'b1;
                dec_imm = imm_u;
                dec_op  = AUIPC_I;
            end
            OPC_JAL: begin
                fmt_wr  = 1'b1;
                dec_imm = imm_j;
                dec_op  = JAL_I;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1;
                fmt_wr   = 1'b1;
                dec_imm  = imm_i;
                if (funct3 == 3'b000) dec_op = JALR_I;
            end
            default: dec_op = INVALID_I;
        endcase
        if (dec_op == INVALID_I) begin
            fmt_wr   = 1'b0;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
            dec_imm  = '0;
        end
    end

    assign dec_wr_reg = fmt_wr && (rd != '0);

    // Operand read
    logic [DBITS-1:0] rs1_val;
    logic [DBITS-1:0] rs2_val;

    de_regfile u_rf (
        .clk      (clk),
        .rst_n    (reset),
        .we_i     (wb.wr_reg_WB),
        .waddr_i  (wb.wregno_WB),
        .wdata_i  (wb.regval_WB),
        .raddr1_i (rs1),
        .rdata1_o (rs1_val),
        .raddr2_i (rs2),
        .rdata2_o (rs2_val)
    );

    // Hazard detection: a busy register is fine if WB is retiring it right now
    logic [REGWORDS-1:0] busy_q;
    logic [REGWORDS-1:0] busy_d;
    logic                wb_hit_rs1;
    logic                wb_hit_rs2;
    logic                wb_hit_rd;
    logic                stall_de;
    logic                issue;

    assign wb_hit_rs1 = wb.wr_reg_WB && (wb.wregno_WB == rs1);
    assign wb_hit_rs2 = wb.wr_reg_WB && (wb.wregno_WB == rs2);
    assign wb_hit_rd  = wb.wr_reg_WB && (wb.wregno_WB == rd);

    assign stall_de = fe.valid && !br_cond_AGEX &&
                      ((uses_rs1   && busy_q[rs1] && !wb_hit_rs1) ||
                       (uses_rs2   && busy_q[rs2] && !wb_hit_rs2) ||
                       (dec_wr_reg && busy_q[rd]  && !wb_hit_rd));

    assign issue = fe.valid && !br_cond_AGEX && !stall_de;

    // Busy bits: WB retire clears, a newly issued producer sets and wins a same-register tie
    always_comb begin
        busy_d = busy_q;
        if (wb.wr_reg_WB) begin
            busy_d[wb.wregno_WB] = 1'b0;
        end
        if (issue && dec_wr_reg) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    de_latch_t de_latch_q;
    de_latch_t de_latch_d;

    // Next DE latch: bubble on flush, stall or empty FE latch; otherwise the decoded instruction
    always_comb begin
        de_latch_d            = '0;
        de_latch_d.bus_canary = BUS_CANARY_VALUE;
        if (issue) begin
            de_latch_d.valid      = 1'b1;
            de_latch_d.inst       = fe.inst;
            de_latch_d.PC         = fe.PC;
            de_latch_d.pcplus     = fe.pcplus;
            de_latch_d.op_I       = dec_op;
            de_latch_d.inst_count = fe.inst_count;
            de_latch_d.rs1_val    = rs1_val;
            de_latch_d.rs2_val    = rs2_val;
            de_latch_d.wregno     = dec_wr_reg ? rd : '0;
            de_latch_d.wr_reg     = dec_wr_reg;
            de_latch_d.sxt_imm    = dec_imm;
        end
    end

    // Stage state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_latch_q <= '0;
            busy_q     <= '0;
        end else begin
            de_latch_q <= de_latch_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.DE_latch_out  = de_latch_q;
    assign bus.from_DE_to_FE = stall_de;

endmodule
